// File: rtl/mux_logic_pkg.sv
// Shared opcode definitions for the mux-based logic unit.
package mux_logic_pkg;
    localparam int OP_W = 3;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_NAND = 3'd1;
    localparam op_t OP_OR   = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_NOTA = 3'd4;
    localparam op_t OP_XOR  = 3'd5;
    localparam op_t OP_XNOR = 3'd6;
    localparam op_t OP_ACC  = 3'd7;
endpackage

// File: rtl/mux_logic_unit_if.sv
// Operand/result bundle for mux_logic_unit; master is the upstream/downstream driver side.
interface mux_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    import mux_logic_pkg::*;

    // Valid/ready: a beat transfers on a rising edge where valid && ready are both high;
    // valid holds with stable payload until it transfers, and ready may depend on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_t              op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] tx_count;

    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, y, acc, tx_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, y, acc, tx_count
    );
endinterface

// File: rtl/mux_gate_slice.sv
// One result bit: a 2:1 mux selected by the A bit, with b, ~b or a constant on each leg.
module mux_gate_slice
    import mux_logic_pkg::*;
(
    input  logic sel,
    input  logic b,
    input  op_t  op,
    output logic y
);
    logic leg0;
    logic leg1;

    always_comb begin
        leg0 = 1'b0;
        leg1 = 1'b0;
        case (op)
            OP_AND:  begin leg0 = 1'b0; leg1 = b;    end
            OP_NAND: begin leg0 = 1'b1; leg1 = ~b;   end
            OP_OR:   begin leg0 = b;    leg1 = 1'b1; end
            OP_NOR:  begin leg0 = ~b;   leg1 = 1'b0; end
            OP_NOTA: begin leg0 = 1'b1; leg1 = 1'b0; end
            OP_XOR:  begin leg0 = b;    leg1 = ~b;   end
            OP_XNOR: begin leg0 = ~b;   leg1 = b;    end
            default: begin leg0 = 1'b0; leg1 = 1'b0; end
        endcase
    end

    assign y = sel ? leg1 : leg0;
endmodule

// File: rtl/mux_logic_unit.sv
// Registered mux-logic unit with a single-entry output stage, accumulator and
// saturating handshake counter.
module mux_logic_unit
    import mux_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    mux_logic_unit_if.slave  bus
);
    logic [WIDTH-1:0] mux_y;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            mux_gate_slice u_slice (
                .sel (bus.a[i]),
                .b   (bus.b[i]),
                .op  (bus.op),
                .y   (mux_y[i])
            );
        end
    endgenerate

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_res;

    always_comb begin
        in_ready    = !out_valid_q || bus.out_ready;
        accept      = bus.in_valid && in_ready;
        // A clear in the same cycle as an ACC beat is applied before accumulating.
        acc_base    = bus.acc_clr ? '0 : acc_q;
        acc_res     = acc_base ^ bus.a ^ bus.b;

        out_valid_d = out_valid_q;
        y_d         = y_q;
        acc_d       = acc_base;
        tx_count_d  = tx_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            if (bus.op == OP_ACC) begin
                y_d   = acc_res;
                acc_d = acc_res;
            end else begin
                y_d   = mux_y;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && bus.out_ready && (tx_count_q != {CNT_W{1'b1}})) begin
            tx_count_d = tx_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            acc_q       <= '0;
            tx_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            tx_count_q  <= tx_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.acc       = acc_q;
    assign bus.tx_count  = tx_count_q;
endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed bench for mux_logic_unit: a wide-counter and a 2-bit-counter instance
// share stimulus and are checked against a boolean-level model every cycle.
module tb_mux_logic_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus ();
  mux_logic_unit_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

  mux_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_logic_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  m_y     = '0;
  logic [7:0]  m_acc   = '0;
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;
  int          m_cnt2  = 0;
  logic [7:0]  exp_q[$];

  function automatic logic [7:0] logic_fn(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return ~(a & b);
      2: return a | b;
      3: return ~(a | b);
      4: return ~a;
      5: return a ^ b;
      6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] base;
    logic [7:0] r;
    logic       acc_ok;
    if (rst) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_acc   = '0;
      m_cnt   = 0;
      m_cnt2  = 0;
      exp_q.delete();
    end else begin
      if (m_valid && bus.out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      acc_ok = bus.in_valid && (!m_valid || bus.out_ready);
      base = bus.acc_clr ? 8'h00 : m_acc;
      m_acc = base;
      if (acc_ok) begin
        if (int'(bus.op) == 7) begin
          r     = base ^ bus.a ^ bus.b;
          m_acc = r;
        end else begin
          r = logic_fn(int'(bus.op), bus.a, bus.b);
        end
        m_y     = r;
        m_valid = 1'b1;
        exp_q.push_back(r);
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("y", 32'(bus.y), 32'(m_y));
      check("acc", 32'(bus.acc), 32'(m_acc));
      check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      check("tx_count", 32'(bus.tx_count), 32'(m_cnt));
      check("tx_count2", 32'(bus2.tx_count), 32'(m_cnt2));
      check("y2", 32'(bus2.y), 32'(m_y));
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_beat", 32'(bus.y), 32'hDEAD);
        end else begin
          check("sb_beat", 32'(bus.y), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic clr, input logic ordy);
    bus.in_valid  = v;  bus2.in_valid  = v;
    bus.a         = a;  bus2.a         = a;
    bus.b         = b;  bus2.b         = b;
    bus.op        = op; bus2.op        = op;
    bus.acc_clr   = clr; bus2.acc_clr  = clr;
    bus.out_ready = ordy; bus2.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;
  endtask

  logic [7:0] lit [7];

  initial begin
    lit[0] = 8'hA0; lit[1] = 8'h5F; lit[2] = 8'hFA; lit[3] = 8'h05;
    lit[4] = 8'h0F; lit[5] = 8'h5A; lit[6] = 8'hA5;

    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    chk_en = 1'b1;
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Seven gate ops back to back on one operand pair.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'hF0, 8'hAA, 3'(k), 1'b0, 1'b1);
      step();
      check($sformatf("lit_op%0d", k), 32'(bus.y), 32'(lit[k]));
      check($sformatf("lit_valid%0d", k), 32'(bus.out_valid), 32'h1);
    end

    // Accumulator sequence.
    drive(1'b1, 8'h0F, 8'h00, 3'd7, 1'b0, 1'b1);
    step();
    check("acc_0f", 32'(bus.acc), 32'h0F);
    drive(1'b1, 8'h00, 8'h33, 3'd7, 1'b0, 1'b1);
    step();
    check("acc_3c", 32'(bus.acc), 32'h3C);
    check("acc_y_3c", 32'(bus.y), 32'h3C);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    step();
    check("acc_clr", 32'(bus.acc), 32'h00);
    drive(1'b1, 8'h55, 8'h00, 3'd7, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'h01, 8'h10, 3'd7, 1'b1, 1'b1);
    step();
    check("acc_clr_op7", 32'(bus.acc), 32'h11);
    check("acc_clr_op7_y", 32'(bus.y), 32'h11);

    // Backpressure: hold result for three cycles.
    drive(1'b1, 8'h11, 8'h22, 3'd5, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hFF, 8'h3C, 3'd0, 1'b0, 1'b0);
      step();
      check("hold_y", 32'(bus.y), 32'h33);
      check("hold_in_ready", 32'(bus.in_ready), 32'h0);
    end
    drive(1'b1, 8'hFF, 8'h3C, 3'd0, 1'b0, 1'b1);
    step();
    check("release_y", 32'(bus.y), 32'h3C);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check("drain_valid", 32'(bus.out_valid), 32'h0);

    // Saturating counter on the 2-bit instance.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive((k < 5) ? 1'b1 : 1'b0, 8'(k * 19), 8'h5A, 3'd5, 1'b0, 1'b1);
      step();
      if (k == 1) check("cnt2_1", 32'(bus2.tx_count), 32'd1);
      if (k == 2) check("cnt2_2", 32'(bus2.tx_count), 32'd2);
      if (k == 3) check("cnt2_3", 32'(bus2.tx_count), 32'd3);
      if (k == 4) check("cnt2_4", 32'(bus2.tx_count), 32'd3);
      if (k == 5) check("cnt2_5", 32'(bus2.tx_count), 32'd3);
    end
    check("cnt16_5", 32'(bus.tx_count), 32'd5);

    // Mixed ops with intermittent downstream stall.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 8'(k * 37 + 5), 8'(k * 91 + 3), 3'(k % 8), 1'b0, (k % 3) != 0);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    step();

    // Reset while a result is stalled.
    drive(1'b1, 8'h3C, 8'hC3, 3'd7, 1'b0, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_y", 32'(bus.y), 32'h0);
    check("mid_rst_acc", 32'(bus.acc), 32'h0);
    check("mid_rst_cnt", 32'(bus.tx_count), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    check("post_rst_cnt", 32'(bus.tx_count), 32'h0);

    chk_en = 1'b0;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
